// File: rtl/i2c_temp_poller.sv
// rtl/i2c_temp_poller.sv - multi-sensor I2C temperature poller with integrated SCL timing
// Open-drain SCL/SDA enables, per-channel two-byte reads tagged with channel index.
module i2c_temp_poller #(
    parameter int         CLK_DIV   = 250,
    parameter int         NUM_CH    = 4,
    parameter logic [6:0] BASE_ADDR = 7'b1001000,
    parameter int         POLL_GAP  = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_auto_en,
    input  logic [NUM_CH-1:0] i_ch_mask,
    input  logic              i_sda_in,
    output logic              o_scl_oe,
    output logic              o_sda_oe,
    output logic              o_busy,
    output logic [15:0]       o_data_out,
    output logic [2:0]        o_data_ch,
    output logic              o_data_valid,
    output logic              o_nack_err,
    output logic              o_sweep_done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_RD_MSB, S_MACK,
        S_RD_LSB, S_MNACK, S_STOP, S_NEXT, S_GAP
    } state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_q;
    logic [2:0]        r_bit;
    logic [7:0]        r_sh;
    logic [7:0]        r_msb;
    logic [NUM_CH-1:0] r_pend;
    logic [2:0]        r_ch;
    logic              r_ok;
    logic              r_sweep_end;
    logic [GAP_W-1:0]  r_gap;

    function automatic logic [2:0] f_lowest(input logic [NUM_CH-1:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] f_onehot(input logic [2:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

    // Address wraps modulo 128 through the 7-bit add.
    function automatic logic [7:0] f_addr(input logic [2:0] ch);
        return {BASE_ADDR + {4'b0000, ch}, 1'b1};
    endfunction

    logic [2:0] w_first_ch;
    logic [2:0] w_next_ch;
    logic       w_qend;
    logic       w_sample;
    logic       w_gap_end;
    logic       w_go;

    assign w_first_ch = f_lowest(i_ch_mask);
    assign w_next_ch  = f_lowest(r_pend);
    assign w_qend     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_sample   = w_qend && (r_q == 2'd2) &&
                        (r_state == S_AACK || r_state == S_RD_MSB || r_state == S_RD_LSB);
    assign w_gap_end  = (r_gap == GAP_W'(POLL_GAP - 1));
    assign w_go       = (r_state == S_IDLE && (i_start || i_auto_en)) ||
                        (r_state == S_GAP && w_gap_end && r_sweep_end && i_auto_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_q          <= '0;
            r_bit        <= '0;
            r_sh         <= '0;
            r_msb        <= '0;
            r_pend       <= '0;
            r_ch         <= '0;
            r_ok         <= 1'b0;
            r_sweep_end  <= 1'b0;
            r_gap        <= '0;
            o_scl_oe     <= 1'b0;
            o_sda_oe     <= 1'b0;
            o_busy       <= 1'b0;
            o_data_out   <= '0;
            o_data_ch    <= '0;
            o_data_valid <= 1'b0;
            o_nack_err   <= 1'b0;
            o_sweep_done <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_nack_err   <= 1'b0;
            o_sweep_done <= 1'b0;
            if (w_go) begin
                r_div    <= '0;
                r_q      <= '0;
                r_bit    <= '0;
                o_scl_oe <= 1'b0;
                o_sda_oe <= 1'b0;
                r_ch     <= w_first_ch;
                r_sh     <= f_addr(w_first_ch);
                r_pend   <= i_ch_mask & ~f_onehot(w_first_ch);
                o_busy   <= (i_ch_mask != '0);
                r_state  <= (i_ch_mask == '0) ? S_NEXT : S_START;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_NEXT: begin
                        r_div <= '0;
                        r_q   <= '0;
                        r_bit <= '0;
                        r_gap <= '0;
                        if (r_pend == '0) begin
                            o_sweep_done <= 1'b1;
                            o_busy       <= 1'b0;
                            r_sweep_end  <= 1'b1;
                            r_state      <= i_auto_en ? S_GAP : S_IDLE;
                        end else begin
                            r_ch        <= w_next_ch;
                            r_sh        <= f_addr(w_next_ch);
                            r_pend      <= r_pend & ~f_onehot(w_next_ch);
                            r_sweep_end <= 1'b0;
                            r_state     <= i_auto_en ? S_GAP : S_START;
                        end
                    end
                    S_GAP: begin
                        if (w_gap_end) r_state <= r_sweep_end ? S_IDLE : S_START;
                        else           r_gap   <= r_gap + 1'b1;
                    end
                    default: begin
                        if (w_sample) r_sh <= {r_sh[6:0], i_sda_in};
                        if (!w_qend) begin
                            r_div <= r_div + 1'b1;
                        end else begin
                            r_div <= '0;
                            r_q   <= r_q + 2'd1;
                            if (r_q != 2'd3) begin
                                // SCL low in Q0-Q1 of every bit except the START condition.
                                o_scl_oe <= (r_q == 2'd0) && (r_state != S_START);
                                if (r_state == S_START && r_q == 2'd1) o_sda_oe <= 1'b1;
                                if (r_state == S_STOP  && r_q == 2'd2) o_sda_oe <= 1'b0;
                            end else begin
                                o_scl_oe <= 1'b1;
                                o_sda_oe <= 1'b0;
                                case (r_state)
                                    S_START: begin
                                        r_state  <= S_ADDR;
                                        o_sda_oe <= ~r_sh[7];
                                    end
                                    S_ADDR: begin
                                        r_sh  <= {r_sh[6:0], 1'b0};
                                        r_bit <= r_bit + 3'd1;
                                        if (r_bit == 3'd7) r_state  <= S_AACK;
                                        else               o_sda_oe <= ~r_sh[6];
                                    end
                                    S_AACK: begin
                                        if (r_sh[0]) begin
                                            o_nack_err <= 1'b1;
                                            o_data_ch  <= r_ch;
                                            r_ok       <= 1'b0;
                                            o_sda_oe   <= 1'b1;
                                            r_state    <= S_STOP;
                                        end else begin
                                            r_state    <= S_RD_MSB;
                                        end
                                    end
                                    S_RD_MSB: begin
                                        r_bit <= r_bit + 3'd1;
                                        if (r_bit == 3'd7) begin
                                            r_msb    <= r_sh;
                                            o_sda_oe <= 1'b1;
                                            r_state  <= S_MACK;
                                        end
                                    end
                                    S_MACK: r_state <= S_RD_LSB;
                                    S_RD_LSB: begin
                                        r_bit <= r_bit + 3'd1;
                                        if (r_bit == 3'd7) r_state <= S_MNACK;
                                    end
                                    S_MNACK: begin
                                        r_ok     <= 1'b1;
                                        o_sda_oe <= 1'b1;
                                        r_state  <= S_STOP;
                                    end
                                    S_STOP: begin
                                        o_scl_oe <= 1'b0;
                                        r_state  <= S_NEXT;
                                        if (r_ok) begin
                                            o_data_valid <= 1'b1;
                                            o_data_out   <= {r_msb, r_sh};
                                            o_data_ch    <= r_ch;
                                        end
                                    end
                                    default: r_state <= S_IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_temp_poller.sv
// tb/tb_i2c_temp_poller.sv - scoreboard bench for i2c_temp_poller with an open-drain sensor model
module tb_i2c_temp_poller;
    localparam logic [6:0] BASE = 7'b1001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        auto_en;
    logic [3:0]  ch_mask;
    logic        sda_in;
    logic        scl_oe, sda_oe, busy;
    logic [15:0] data_out;
    logic [2:0]  data_ch;
    logic        data_valid, nack_err, sweep_done;
    logic        slv_pull = 1'b0;

    always #5 clk = ~clk;
    assign sda_in = ~(sda_oe | slv_pull);

    i2c_temp_poller #(.CLK_DIV(2), .NUM_CH(4), .BASE_ADDR(BASE), .POLL_GAP(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_auto_en(auto_en),
        .i_ch_mask(ch_mask), .i_sda_in(sda_in), .o_scl_oe(scl_oe), .o_sda_oe(sda_oe),
        .o_busy(busy), .o_data_out(data_out), .o_data_ch(data_ch),
        .o_data_valid(data_valid), .o_nack_err(nack_err), .o_sweep_done(sweep_done)
    );

    typedef struct {
        logic        kind;
        logic [2:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t       q_exp[$];
    logic [7:0] q_addr[$];
    int n_chk = 0, n_pass = 0;
    int n_start = 0, n_stop = 0, n_sd = 0;
    logic [3:0]  ack_en = 4'hF;
    logic [15:0] sens[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic kind, input logic [2:0] ch, input logic [15:0] d);
        exp_t e;
        e.kind = kind; e.ch = ch; e.data = d;
        q_exp.push_back(e);
    endtask

    task automatic wait_dv(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!data_valid && cyc < 3000);
        if (cyc >= 3000) check("dv_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (sweep_done) seen = 1;
        end
        if (!seen) check("sweep_done_timeout", 0, 1);
    endtask

    task automatic pulse_start(input logic [3:0] m);
        @(negedge clk);
        ch_mask = m;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Sensor model: decodes START/STOP and bits from bus levels, answers on SCL falling edges.
    logic [7:0]  m_rx;
    int          m_bit;
    logic        m_act = 1'b0, m_ack = 1'b0;
    logic [15:0] m_word;
    logic        m_pscl = 1'b1, m_psda = 1'b1;

    always @(negedge clk) begin
        logic cs, cd;
        int   ch;
        if (!rst_n) begin
            slv_pull = 1'b0; m_act = 1'b0; m_pscl = 1'b1; m_psda = 1'b1;
        end else begin
            cs = ~scl_oe;
            cd = sda_in;
            if (m_pscl && cs && m_psda && !cd) begin
                m_act = 1'b1; m_bit = 0; m_ack = 1'b0; slv_pull = 1'b0; n_start++;
            end else if (m_pscl && cs && !m_psda && cd) begin
                m_act = 1'b0; slv_pull = 1'b0; n_stop++;
            end else if (m_act && !m_pscl && cs) begin
                if (m_bit < 8) m_rx = {m_rx[6:0], cd};
                if (m_bit == 7) begin
                    if (q_addr.size() == 0) check("addr_unexpected", q_addr.size(), 1);
                    else                    check("addr_byte", m_rx, q_addr.pop_front());
                    ch = int'(m_rx[7:1]) - int'(BASE);
                    m_ack = m_rx[0] && ch >= 0 && ch < 4 && ack_en[ch];
                    if (m_ack) m_word = sens[ch];
                end
                m_bit++;
            end else if (m_act && m_pscl && !cs) begin
                if (m_bit == 8)                     slv_pull = m_ack;
                else if (m_bit >= 9 && m_bit <= 16)  slv_pull = m_ack && !m_word[24 - m_bit];
                else if (m_bit >= 18 && m_bit <= 25) slv_pull = m_ack && !m_word[25 - m_bit];
                else                                 slv_pull = 1'b0;
            end
            m_pscl = cs;
            m_psda = cd;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sweep_done) n_sd++;
            if (data_valid && nack_err) check("dv_nack_exclusive", 1, 0);
            if (data_valid || nack_err) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_event", q_exp.size(), 1);
                end else begin
                    e = q_exp.pop_front();
                    check("evt_kind", nack_err, e.kind);
                    check("evt_ch", data_ch, e.ch);
                    check("evt_data", data_out, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int cyc, st0, sp0, sd0;
        bit driven, busy_seen;
        rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; ch_mask = 4'h0;
        sens[0] = 16'h1980; sens[1] = 16'h0A00; sens[2] = 16'h0000; sens[3] = 16'hF380;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_pulses", {data_valid, nack_err, sweep_done}, 0);
        rst_n = 1'b1;

        // Single channel read, latency and sweep_done timing.
        q_addr.push_back(8'h91);
        push_exp(1'b0, 3'd0, 16'h1980);
        pulse_start(4'b0001);
        wait_dv(cyc);
        check("t2_latency", cyc, 232);
        check("t2_data_out", data_out, 16'h1980);
        @(posedge clk); #1;
        check("t2_sweep_done_next", sweep_done, 1);
        check("t2_busy_clear", busy, 0);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of the address byte.
        pulse_start(4'b0001);
        repeat (20) @(negedge clk);
        check("t1_busy_mid", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_scl_rel", scl_oe, 0);
        check("t1_sda_rel", sda_oe, 0);
        check("t1_busy", busy, 0);
        check("t1_data_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Two sparse channels; a start pulse while busy is ignored.
        sd0 = n_sd;
        q_addr.push_back(8'h93); q_addr.push_back(8'h97);
        push_exp(1'b0, 3'd1, 16'h0A00);
        push_exp(1'b0, 3'd3, 16'hF380);
        pulse_start(4'b1010);
        repeat (100) @(negedge clk);
        pulse_start(4'b1111);
        wait_done(2000);
        repeat (20) @(negedge clk);
        check("t3_sweeps", n_sd - sd0, 1);
        check("t3_sb_empty", q_exp.size(), 0);

        // Address NACK on channel 0, channel 1 still read.
        ack_en = 4'b1110;
        sens[1] = 16'h1234;
        st0 = n_start; sp0 = n_stop;
        q_addr.push_back(8'h91); q_addr.push_back(8'h93);
        push_exp(1'b1, 3'd0, 16'hF380);
        push_exp(1'b0, 3'd1, 16'h1234);
        pulse_start(4'b0011);
        wait_done(2000);
        repeat (5) @(negedge clk);
        check("t4_starts", n_start - st0, 2);
        check("t4_stops", n_stop - sp0, 2);
        check("t4_sb_empty", q_exp.size(), 0);
        ack_en = 4'hF;

        // Empty mask: no bus activity, sweep_done one cycle after start.
        driven = 0; busy_seen = 0;
        pulse_start(4'b0000);
        check("t5_sd_early", sweep_done, 0);
        @(posedge clk); #1;
        check("t5_sd_pulse", sweep_done, 1);
        for (int i = 0; i < 20; i++) begin
            if (scl_oe || sda_oe) driven = 1;
            if (busy) busy_seen = 1;
            @(posedge clk); #1;
        end
        check("t5_bus_idle", driven, 0);
        check("t5_busy", busy_seen, 0);

        // Free-running mode, then drop auto_en during the third transaction.
        sens[0] = 16'hABCD;
        st0 = n_start;
        for (int i = 0; i < 3; i++) begin
            q_addr.push_back(8'h91);
            push_exp(1'b0, 3'd0, 16'hABCD);
        end
        @(negedge clk);
        ch_mask = 4'b0001;
        auto_en = 1'b1;
        @(posedge clk); #1;
        wait_dv(cyc);
        check("t6_first_latency", cyc, 232);
        wait_dv(cyc);
        check("t6_interval", cyc, 241);
        repeat (50) @(negedge clk);
        auto_en = 1'b0;
        wait_done(2000);
        @(negedge clk);
        check("t6_busy_clear", busy, 0);
        driven = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (scl_oe || busy) driven = 1;
        end
        check("t6_no_restart", driven, 0);
        check("t6_starts", n_start - st0, 3);
        check("end_sb_empty", q_exp.size(), 0);
        check("end_addr_empty", q_addr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
